text_buffer_ctrl: RTL and testbench

TEXT_BUFFER_CTRL -- requirements
Module: text_buffer_ctrl

---
 rtl/text_buffer_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_text_buffer_ctrl.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/text_buffer_ctrl.sv
// text_buffer_ctrl
//   Single-line character store between the keyboard decoder and the VGA
//   text renderer. Keys are edited into a DEPTH-cell line (backspace,
//   clear, cursor left/right, printable store). The renderer reads cells
//   through a registered, read-before-write port.
//
//   Optional macro TEXTBUF_WRAP_EN:
//     defined   - a store at the last cell wraps the cursor to 0 and pulses
//                 overflow.
//     undefined - a store at the last cell parks the cursor at DEPTH, and
//                 any further store is rejected with an overflow pulse.
module text_buffer_ctrl #(
  parameter int         DEPTH = 70,
  parameter logic [7:0] BLANK = 8'hFF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_valid,
  input  logic [7:0] key_code,
  output logic       key_ready,
  input  logic [6:0] rd_addr,
  output logic [7:0] rd_data,
  output logic [6:0] cursor_idx,
  output logic       overflow
);

  localparam logic [6:0] DEPTH_C   = 7'(DEPTH);
  localparam logic [6:0] LAST_C    = 7'(DEPTH - 1);
  localparam logic [7:0] KEY_BS    = 8'h08;
  localparam logic [7:0] KEY_CLR   = 8'h1B;
  localparam logic [7:0] KEY_LEFT  = 8'h80;
  localparam logic [7:0] KEY_RIGHT = 8'h81;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_IDLE  = 1'b1
  } state_t;

  state_t     state_r;
  state_t     state_nxt_s;
  logic [6:0] sweep_r;
  logic [6:0] sweep_nxt_s;
  logic [6:0] cursor_r;
  logic [6:0] cursor_nxt_s;
  logic       overflow_r;
  logic       overflow_nxt_s;
  logic       key_ready_r;
  logic [7:0] rd_data_r;
  logic       accept_s;
  logic       we_s;
  logic [6:0] waddr_s;
  logic [7:0] wdata_s;
  logic [7:0] mem_r [0:DEPTH-1];

  // A key is only taken while the line is idle; anything else is dropped.
  assign accept_s = key_valid & key_ready_r;

  // State, sweep pointer, cursor and registered status outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_CLEAR;
      sweep_r     <= 7'd0;
      cursor_r    <= 7'd0;
      overflow_r  <= 1'b0;
      key_ready_r <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      sweep_r     <= sweep_nxt_s;
      cursor_r    <= cursor_nxt_s;
      overflow_r  <= overflow_nxt_s;
      key_ready_r <= (state_nxt_s == ST_IDLE);
    end
  end

  // Next-state: sweep every cell once, then idle until a clear command.
  always_comb begin
    state_nxt_s = state_r;
    sweep_nxt_s = sweep_r;
    case (state_r)
      ST_CLEAR: begin
        if (sweep_r == LAST_C) begin
          state_nxt_s = ST_IDLE;
          sweep_nxt_s = 7'd0;
        end else begin
          sweep_nxt_s = sweep_r + 7'd1;
        end
      end
      ST_IDLE: begin
        if (accept_s && (key_code == KEY_CLR)) begin
          state_nxt_s = ST_CLEAR;
          sweep_nxt_s = 7'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      default: begin
        state_nxt_s = ST_CLEAR;
        sweep_nxt_s = 7'd0;
      end
    endcase
  end

  // Outputs/datapath: cell write request, cursor update, overflow pulse.
  always_comb begin
    we_s           = 1'b0;
    waddr_s        = sweep_r;
    wdata_s        = BLANK;
    cursor_nxt_s   = cursor_r;
    overflow_nxt_s = 1'b0;
    case (state_r)
      ST_CLEAR: begin
        we_s    = 1'b1;
        waddr_s = sweep_r;
        wdata_s = BLANK;
      end
      ST_IDLE: begin
        if (accept_s) begin
          case (key_code)
            KEY_BS: begin
              if (cursor_r != 7'd0) begin
                cursor_nxt_s = cursor_r - 7'd1;
                we_s         = 1'b1;
                waddr_s      = cursor_r - 7'd1;
                wdata_s      = BLANK;
              end else begin
                cursor_nxt_s = cursor_r;
              end
            end
            KEY_CLR: begin
              cursor_nxt_s = 7'd0;
            end
            KEY_LEFT: begin
              if (cursor_r != 7'd0) begin
                cursor_nxt_s = cursor_r - 7'd1;
              end else begin
                cursor_nxt_s = cursor_r;
              end
            end
            KEY_RIGHT: begin
              if (cursor_r < LAST_C) begin
                cursor_nxt_s = cursor_r + 7'd1;
              end else begin
                cursor_nxt_s = cursor_r;
              end
            end
            default: begin
              if (key_code < 8'h80) begin
                if (cursor_r < DEPTH_C) begin
                  we_s    = 1'b1;
                  waddr_s = cursor_r;
                  wdata_s = key_code;
                  if (cursor_r == LAST_C) begin
`ifdef TEXTBUF_WRAP_EN
                    cursor_nxt_s   = 7'd0;
                    overflow_nxt_s = 1'b1;
`else
                    cursor_nxt_s   = DEPTH_C;
`endif
                  end else begin
                    cursor_nxt_s = cursor_r + 7'd1;
                  end
                end else begin
                  // Line full: refuse the store, memory untouched.
                  overflow_nxt_s = 1'b1;
                end
              end else begin
                // Unassigned command codes are ignored.
                cursor_nxt_s = cursor_r;
              end
            end
          endcase
        end else begin
          we_s = 1'b0;
        end
      end
      default: begin
        we_s = 1'b0;
      end
    endcase
  end

  // Cell storage; writes are suppressed while reset is held so an
  // interrupted sweep leaves the remaining cells as they were.
  always_ff @(posedge clk) begin
    if (we_s && !reset) begin
      mem_r[waddr_s] <= wdata_s;
    end
  end

  // Registered renderer read; out-of-line addresses read as empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_data_r <= BLANK;
    end else if (rd_addr < DEPTH_C) begin
      rd_data_r <= mem_r[rd_addr];
    end else begin
      rd_data_r <= BLANK;
    end
  end

  assign key_ready  = key_ready_r;
  assign rd_data    = rd_data_r;
  assign cursor_idx = cursor_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_text_buffer_ctrl.sv
// Scoreboard bench for text_buffer_ctrl: the driver applies one stimulus
// per cycle at the falling edge, a line-level reference model predicts the
// post-edge outputs and queues them, and a monitor compares after each
// rising edge.
module tb_text_buffer_ctrl;

  localparam int D = 70;

  logic       clk;
  logic       reset;
  logic       key_valid;
  logic [7:0] key_code;
  logic       key_ready;
  logic [6:0] rd_addr;
  logic [7:0] rd_data;
  logic [6:0] cursor_idx;
  logic       overflow;

  text_buffer_ctrl #(.DEPTH(D), .BLANK(8'hFF)) dut (
    .clk        (clk),
    .reset      (reset),
    .key_valid  (key_valid),
    .key_code   (key_code),
    .key_ready  (key_ready),
    .rd_addr    (rd_addr),
    .rd_data    (rd_data),
    .cursor_idx (cursor_idx),
    .overflow   (overflow)
  );

  typedef struct {
    bit         chk_rd;
    logic [7:0] rd;
    int         cur;
    logic       ovf;
    logic       rdy;
  } exp_t;

  exp_t sb_q[$];

  // Reference model: the text line as an array, a cursor, and the number
  // of sweep cycles still owed before keys are accepted again.
  logic [7:0] mem_m [0:D-1];
  bit         known_m [0:D-1];
  int         cur_m;
  int         clear_left_m;

  int n_checks;
  int n_fail;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply a key to the model line.
  task automatic model_key(input logic [7:0] code, output logic ovf);
    ovf = 1'b0;
    if (code == 8'h08) begin
      if (cur_m > 0) begin
        cur_m = cur_m - 1;
        mem_m[cur_m] = 8'hFF;
      end
    end else if (code == 8'h1B) begin
      cur_m = 0;
      clear_left_m = D;
    end else if (code == 8'h80) begin
      cur_m = (cur_m > 0) ? cur_m - 1 : 0;
    end else if (code == 8'h81) begin
      cur_m = (cur_m + 1 > D - 1) ? cur_m : cur_m + 1;
    end else if (code < 8'h80) begin
      if (cur_m >= D) begin
        ovf = 1'b1;
      end else begin
        mem_m[cur_m] = code;
        known_m[cur_m] = 1'b1;
        cur_m = cur_m + 1;
`ifdef TEXTBUF_WRAP_EN
        if (cur_m == D) begin
          cur_m = 0;
          ovf = 1'b1;
        end
`endif
      end
    end
  endtask

  // One clock of stimulus plus the model's prediction for the next edge.
  task automatic step(input bit rst, input bit v, input logic [7:0] code, input logic [6:0] addr);
    exp_t e;
    logic ovf;
    @(negedge clk);
    reset     = rst;
    key_valid = v;
    key_code  = code;
    rd_addr   = addr;
    ovf       = 1'b0;
    if (rst) begin
      e.chk_rd = 1'b1;
      e.rd     = 8'hFF;
    end else if (addr >= 7'(D)) begin
      e.chk_rd = 1'b1;
      e.rd     = 8'hFF;
    end else begin
      e.chk_rd = known_m[addr];
      e.rd     = mem_m[addr];
    end
    if (rst) begin
      cur_m = 0;
      clear_left_m = D;
    end else if (clear_left_m > 0) begin
      mem_m[D - clear_left_m]   = 8'hFF;
      known_m[D - clear_left_m] = 1'b1;
      clear_left_m = clear_left_m - 1;
    end else if (v) begin
      model_key(code, ovf);
    end
    e.cur = cur_m;
    e.ovf = ovf;
    e.rdy = (!rst && clear_left_m == 0);
    sb_q.push_back(e);
  endtask

  function automatic logic [6:0] rnd_addr();
    return 7'($urandom_range(0, 79));
  endfunction

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, rnd_addr());
  endtask

  task automatic key(input logic [7:0] code);
    step(1'b0, 1'b1, code, rnd_addr());
  endtask

  task automatic scan();
    for (int a = 0; a < D; a++) step(1'b0, 1'b0, 8'h00, 7'(a));
    step(1'b0, 1'b0, 8'h00, 7'd127);
  endtask

  // Count cycles until key_ready rises; optionally fire keys meanwhile.
  task automatic wait_ready(input string nm, input int exp, input bit spam);
    int cnt;
    cnt = 0;
    while (cnt < 300) begin
      step(1'b0, spam, 8'($urandom_range(32, 126)), rnd_addr());
      @(posedge clk);
      #2;
      cnt++;
      if (key_ready === 1'b1) break;
    end
    check(nm, 32'(cnt), 32'(exp));
  endtask

  // Monitor: compare every queued expectation just after the rising edge.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      if (e.chk_rd) check("rd_data", 32'(rd_data), 32'(e.rd));
      check("cursor_idx", 32'(cursor_idx), 32'(e.cur));
      check("overflow", 32'(overflow), 32'(e.ovf));
      check("key_ready", 32'(key_ready), 32'(e.rdy));
    end
  end

  initial begin
    int r;
    logic [7:0] c;
    n_checks  = 0;
    n_fail    = 0;
    reset     = 1'b1;
    key_valid = 1'b0;
    key_code  = 8'h00;
    rd_addr   = 7'd0;
    cur_m     = 0;
    clear_left_m = D;
    for (int i = 0; i < D; i++) begin
      mem_m[i]   = 8'hFF;
      known_m[i] = 1'b0;
    end

    // Reset, release, first sweep latency, then every cell reads blank.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 8'h41, rnd_addr());
    wait_ready("ready_after_reset", D, 1'b0);
    scan();

    // Simple typing and readback.
    key(8'h31);
    key(8'h32);
    key(8'h33);
    idle(2);
    scan();

    // Backspace past the start, then left at zero.
    for (int i = 0; i < 4; i++) key(8'h08);
    key(8'h80);
    scan();

    // Fill the line and push one key past the end.
    for (int i = 0; i < D + 1; i++) key(8'h41);
    idle(2);
    scan();
    key(8'h81);
    key(8'h08);
    key(8'h80);
    key(8'h81);
    key(8'hC5);

    // Clear at cursor 5 while keys keep arriving during the sweep.
    key(8'h1B);
    wait_ready("clear_latency_a", D, 1'b0);
    for (int i = 0; i < 5; i++) key(8'($urandom_range(32, 126)));
    key(8'h1B);
    wait_ready("clear_latency_b", D, 1'b1);
    scan();

    // Randomized editing traffic.
    for (int i = 0; i < 1500; i++) begin
      r = $urandom_range(0, 99);
      if (r < 45)      c = 8'($urandom_range(32, 126));
      else if (r < 55) c = 8'h08;
      else if (r < 65) c = 8'h80;
      else if (r < 75) c = 8'h81;
      else if (r < 82) c = 8'($urandom_range(130, 255));
      else if (r < 83) c = 8'h1B;
      else             c = 8'($urandom_range(0, 127));
      step(1'b0, ($urandom_range(0, 4) != 0), c, rnd_addr());
    end
    idle(D + 2);
    scan();

    // Reset in the middle of a sweep restarts it from the first cell.
    for (int i = 0; i < 40; i++) key(8'($urandom_range(32, 126)));
    key(8'h1B);
    for (int i = 0; i < 30; i++) step(1'b0, 1'b0, 8'h00, 7'(30 + (i % 40)));
    step(1'b1, 1'b0, 8'h00, 7'd45);
    step(1'b1, 1'b1, 8'h42, 7'd50);
    wait_ready("ready_after_midsweep_reset", D, 1'b0);
    scan();

    @(posedge clk);
    #3;
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
